ufo: RTL and testbench
======================

// Module: ufo
// PURPOSE
//   Mystery-ship (UFO) sprite controller. Peer of the invader, missile and laser
//   stages: produces ufo_x/ufo_y/ufo_active/ufo_exploding for vga_controller and
//   consumes its ufo_collision flag. Emits a one-clk bonus pulse with a point value
//   to score_logic. Spawns at pseudo-random intervals and crosses the top row once
//   per spawn.
// PARAMETERS
//   SCREEN_W        640     visible width, px
//   UFO_W           16      sprite width, px
//   UFO_Y           40      fixed sprite top row, px
//   SPEED           2       px moved per frame pulse
//   SPAWN_MIN       600     minimum frames between spawns (>=1)
//   SPAWN_MASK      8'hFF   mask applied to lfsr[7:0], added to SPAWN_MIN
//   EXPLODE_FRAMES  30      frames the explosion stays on screen (>=1)
// PORTS
//   clk            in   1   system clock
//   rst            in   1   asynchronous reset, active-high
//   arst           in   1   debounced game-restart button; synchronous, same effect as rst
//   frame          in   1   one-clk pulse per video frame, synchronous to clk
//   done           in   1   game over; freezes block
//   ufo_collision  in   1   level, laser overlaps UFO sprite (from vga_controller)
//   ufo_active     out  1   UFO drawn (FLY state)
//   ufo_exploding  out  1   explosion sprite drawn (EXPLODE state)
//   ufo_dir        out  1   0 = moving right, 1 = moving left
//   ufo_x          out  10  sprite left column
//   ufo_y          out  10  sprite top row, constant UFO_Y
//   bonus_valid    out  1   one-clk pulse on a hit
//   bonus_points   out  7   points for the hit; valid with bonus_valid, held after
// BEHAVIOUR
//   - Reset (rst or arst):
//     - state=IDLE, spawn_cnt=SPAWN_MIN, lfsr=16'hACE1.
//     - ufo_active=0, ufo_exploding=0, ufo_dir=0, ufo_x=0, ufo_y=UFO_Y.
//     - bonus_valid=0, bonus_points=0.
//   - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk, not stopped by done.
//   - IDLE:
//     - On each frame, spawn_cnt decrements.
//     - A frame arriving while spawn_cnt==1 enters FLY on the next clk with:
//       - ufo_dir=lfsr[0]
//       - ufo_x = dir ? SCREEN_W-UFO_W : 0
//   - FLY:
//     - Each frame moves SPEED px.
//       - Right-moving: if ufo_x+SPEED > SCREEN_W-UFO_W, go to IDLE instead of moving.
//       - Left-moving: if ufo_x < SPEED, go to IDLE instead of moving.
//     - Compare in 11 bits; ufo_x never wraps.
//   - Entering IDLE from any state reloads spawn_cnt = SPAWN_MIN + (lfsr[7:0] & SPAWN_MASK).
//   - Hit: ufo_collision=1 in FLY goes to EXPLODE next clk.
//     - Same clk: bonus_valid=1; bonus_points = {5,10,15,30}[lfsr[1:0]].
//     - ufo_x holds during EXPLODE.
//     - ufo_collision stays high for many pixels, but exactly one bonus is issued
//       because the state leaves FLY.
//   - EXPLODE: explode_cnt loaded with EXPLODE_FRAMES on entry, decremented per frame.
//     A frame at explode_cnt==1 goes to IDLE.
//   - Outputs: ufo_active = (state==FLY); ufo_exploding = (state==EXPLODE). Both registered.
//   - Latency: frame -> new ufo_x is 1 clk.
//   - Simultaneous frame and collision in FLY: the hit wins; no move that cycle.
//   - ufo_collision in IDLE or EXPLODE is ignored.
//   - done=1:
//     - No state change, no counter decrement, no movement.
//     - Collisions ignored; bonus_valid held 0.
//     - Outputs hold; a UFO in flight stays visible, frozen.
//   - rst/arst mid-FLY or mid-EXPLODE: immediate return to the reset state; no bonus emitted.
//   - State encoding: IDLE=2'd0, FLY=2'd1, EXPLODE=2'd2; 2'd3 recovers to IDLE.
// STRUCTURE
//   - Shared constants go in util/constants.v:
//     - SCREEN_W, UFO_W, UFO_Y
//     - UFO state encodings
//     - bonus point table
//   - One sub-module: ufo_lfsr (16-bit LFSR, clk/rst/arst, seed parameter).
//   - Everything else is one FSM plus the spawn, explode and x counters in ufo.
// TESTING
//   - T1: SPAWN_MIN=4, SPAWN_MASK=0, no collision; reset then 4 frame pulses
//     -> ufo_active=1 one clk after the 4th pulse; ufo_x = 0 or 624 per ufo_dir.
//   - T2: dir=0, no hit -> ufo_x steps 0,2,...,624; next frame gives ufo_active=0
//     and ufo_x never exceeds 624. After 4 further frames the UFO respawns.
//   - T3: dir=1 -> ufo_x steps 624,...,0; next frame returns to IDLE with no
//     underflow (x never shows 1022).
//   - T4: ufo_collision held 20 clk in FLY with a frame pulse in the first clk
//     -> exactly one bonus_valid pulse, bonus_points in {5,10,15,30},
//     ufo_exploding=1, ufo_x unchanged.
//     After EXPLODE_FRAMES=3 frames, ufo_exploding=0.
//   - T5: done=1 during FLY for 10 frames -> ufo_x constant, no state change;
//     collision gives no bonus. After done=0, movement resumes from the same x.
//   - T6: arst pulse mid-EXPLODE -> next clk all outputs at reset values, and the
//     next spawn occurs after 4 frames.

Source files
------------

// File: rtl/ufo_pkg.sv
// Shared constants, state encoding and bonus table for the mystery-ship (UFO) sprite controller.
package ufo_pkg;

   localparam int SCREEN_W = 640;
   localparam int UFO_W    = 16;
   localparam int UFO_Y    = 40;
   localparam int X_MAX    = SCREEN_W - UFO_W;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FLY     = 2'd1,
      ST_EXPLODE = 2'd2
   } ufo_state_t;

   function automatic logic [6:0] bonus_for(input logic [1:0] sel);
      case (sel)
         2'd0:    bonus_for = 7'd5;
         2'd1:    bonus_for = 7'd10;
         2'd2:    bonus_for = 7'd15;
         default: bonus_for = 7'd30;
      endcase
   endfunction

endpackage

// File: rtl/ufo_if.sv
// UFO stage signals: frame/done/collision in, sprite position, state flags and bonus out.
interface ufo_if;

   logic       frame;
   logic       done;
   logic       ufo_collision;
   logic       ufo_active;
   logic       ufo_exploding;
   logic       ufo_dir;
   logic [9:0] ufo_x;
   logic [9:0] ufo_y;
   logic       bonus_valid;
   logic [6:0] bonus_points;

   // The game side drives timing and collision; the UFO stage answers with sprite and score data.
   modport master (
      output frame, done, ufo_collision,
      input  ufo_active, ufo_exploding, ufo_dir, ufo_x, ufo_y, bonus_valid, bonus_points
   );

   modport slave (
      input  frame, done, ufo_collision,
      output ufo_active, ufo_exploding, ufo_dir, ufo_x, ufo_y, bonus_valid, bonus_points
   );

endinterface

// File: rtl/ufo_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that free-runs every clock; exposes its low byte.
module ufo_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arst,
   output logic [7:0] rnd
);

   logic [15:0] lfsr;
   logic        feedback;

   assign feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign rnd      = lfsr[7:0];

   // Keeps running while the game is frozen so spawn timing stays unpredictable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (arst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {feedback, lfsr[15:1]};
      end
   end

endmodule

// File: rtl/ufo.sv
// Mystery-ship controller: random spawn delay, one crossing of the top row, hit -> explosion + bonus.
module ufo
   import ufo_pkg::*;
#(
   parameter int          SPEED          = 2,
   parameter int          SPAWN_MIN      = 600,
   parameter logic [7:0]  SPAWN_MASK     = 8'hFF,
   parameter int          EXPLODE_FRAMES = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic arst,
   ufo_if.slave bus
);

   logic [7:0]  rnd;
   ufo_state_t  state;
   logic [15:0] spawn_cnt;
   logic [15:0] explode_cnt;
   logic [15:0] spawn_reload;
   logic [9:0]  x;
   logic [10:0] x_ext;
   logic        dir;
   logic        active;
   logic        exploding;
   logic        bonus_valid;
   logic [6:0]  bonus_points;
   logic        at_right_edge;
   logic        at_left_edge;

   ufo_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .arst (arst),
      .rnd  (rnd)
   );

   assign spawn_reload  = 16'(SPAWN_MIN) + {8'd0, rnd & SPAWN_MASK};
   assign x_ext         = {1'b0, x};
   assign at_right_edge = (x_ext + 11'(SPEED)) > 11'(X_MAX);
   assign at_left_edge  = x_ext < 11'(SPEED);

   assign bus.ufo_active    = active;
   assign bus.ufo_exploding = exploding;
   assign bus.ufo_dir       = dir;
   assign bus.ufo_x         = x;
   assign bus.ufo_y         = 10'(UFO_Y);
   assign bus.bonus_valid   = bonus_valid;
   assign bus.bonus_points  = bonus_points;

   // One FSM owns state, counters and every output; a hit takes priority over a move on the same clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         spawn_cnt    <= 16'(SPAWN_MIN);
         explode_cnt  <= '0;
         x            <= '0;
         dir          <= 1'b0;
         active       <= 1'b0;
         exploding    <= 1'b0;
         bonus_valid  <= 1'b0;
         bonus_points <= '0;
      end else if (arst) begin
         state        <= ST_IDLE;
         spawn_cnt    <= 16'(SPAWN_MIN);
         explode_cnt  <= '0;
         x            <= '0;
         dir          <= 1'b0;
         active       <= 1'b0;
         exploding    <= 1'b0;
         bonus_valid  <= 1'b0;
         bonus_points <= '0;
      end else begin
         bonus_valid <= 1'b0;
         if (!bus.done) begin
            case (state)
               ST_IDLE: begin
                  if (bus.frame) begin
                     spawn_cnt <= spawn_cnt - 16'd1;
                     if (spawn_cnt == 16'd1) begin
                        state  <= ST_FLY;
                        active <= 1'b1;
                        dir    <= rnd[0];
                        x      <= rnd[0] ? 10'(X_MAX) : 10'd0;
                     end
                  end
               end
               ST_FLY: begin
                  if (bus.ufo_collision) begin
                     state        <= ST_EXPLODE;
                     active       <= 1'b0;
                     exploding    <= 1'b1;
                     explode_cnt  <= 16'(EXPLODE_FRAMES);
                     bonus_valid  <= 1'b1;
                     bonus_points <= bonus_for(rnd[1:0]);
                  end else if (bus.frame) begin
                     if ((!dir && at_right_edge) || (dir && at_left_edge)) begin
                        state     <= ST_IDLE;
                        active    <= 1'b0;
                        spawn_cnt <= spawn_reload;
                     end else if (dir) begin
                        x <= x - 10'(SPEED);
                     end else begin
                        x <= x + 10'(SPEED);
                     end
                  end
               end
               ST_EXPLODE: begin
                  if (bus.frame) begin
                     explode_cnt <= explode_cnt - 16'd1;
                     if (explode_cnt == 16'd1) begin
                        state     <= ST_IDLE;
                        exploding <= 1'b0;
                        spawn_cnt <= spawn_reload;
                     end
                  end
               end
               default: begin
                  state     <= ST_IDLE;
                  active    <= 1'b0;
                  exploding <= 1'b0;
                  spawn_cnt <= spawn_reload;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ufo.sv
// Directed bench for ufo with a short spawn delay (4 frames, no random spread) and a 3-frame explosion.
module tb_ufo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic arst = 1'b0;

   ufo_if u_if ();

   ufo #(
      .SPEED          (2),
      .SPAWN_MIN      (4),
      .SPAWN_MASK     (8'h00),
      .EXPLODE_FRAMES (3)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .arst (arst),
      .bus  (u_if.slave)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] lfsr_m;
   logic [15:0] lfsr_at_frame;
   logic        exp_dir;
   logic [9:0]  exp_x;
   logic [6:0]  points_tbl [4] = '{7'd5, 7'd10, 7'd15, 7'd30};

   // Reference LFSR: Fibonacci, taps 16,14,13,11, reloaded with 16'hACE1 by either reset.
   always @(posedge clk or posedge rst) begin
      if (rst)       lfsr_m <= 16'hACE1;
      else if (arst) lfsr_m <= 16'hACE1;
      else           lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
   end

   task automatic frame_now();
      u_if.frame = 1'b1;
      lfsr_at_frame = lfsr_m;
      @(posedge clk); #1;
      u_if.frame = 1'b0;
   endtask

   task automatic pulse_frame();
      @(posedge clk); #1;
      frame_now();
   endtask

   task automatic pulse_arst();
      @(posedge clk); #1;
      arst = 1'b1;
      @(posedge clk); #1;
      arst = 1'b0;
   endtask

   // want = 0/1 forces that direction by timing the spawning frame; 2 takes whatever comes.
   task automatic spawn_with_dir(input int want);
      int n;
      pulse_arst();
      for (int i = 0; i < 3; i++) pulse_frame();
      @(posedge clk); #1;
      n = 0;
      if (want != 2) begin
         while (lfsr_m[0] != want[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("[TB] FAIL spawn_dir_wait: waited %0d clk, required < 40", n);
      end
      frame_now();
      exp_dir = lfsr_at_frame[0];
      exp_x   = exp_dir ? 10'd624 : 10'd0;
      checks++;
      if (u_if.ufo_active !== 1'b1 || u_if.ufo_dir !== exp_dir || u_if.ufo_x !== exp_x) begin
         errors++;
         $display("[TB] FAIL spawn: active=%0d dir=%0d x=%0d, required active=1 dir=%0d x=%0d",
                  u_if.ufo_active, u_if.ufo_dir, u_if.ufo_x, exp_dir, exp_x);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (u_if.ufo_active !== 1'b0 || u_if.ufo_exploding !== 1'b0 || u_if.ufo_dir !== 1'b0 ||
          u_if.ufo_x !== 10'd0 || u_if.bonus_valid !== 1'b0 || u_if.bonus_points !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: act=%0d exp=%0d dir=%0d x=%0d bv=%0d bp=%0d, required all 0",
                  u_if.ufo_active, u_if.ufo_exploding, u_if.ufo_dir, u_if.ufo_x,
                  u_if.bonus_valid, u_if.bonus_points);
      end
      checks++;
      if (u_if.ufo_y !== 10'd40) begin
         errors++;
         $display("[TB] FAIL reset_y: got %0d, required 40", u_if.ufo_y);
      end
      rst = 1'b0;
   endtask

   task automatic test_spawn();
      pulse_arst();
      for (int i = 0; i < 3; i++) pulse_frame();
      checks++;
      if (u_if.ufo_active !== 1'b0) begin
         errors++;
         $display("[TB] FAIL spawn_early: active=%0d after 3 frames, required 0", u_if.ufo_active);
      end
      pulse_frame();
      exp_dir = lfsr_at_frame[0];
      exp_x   = exp_dir ? 10'd624 : 10'd0;
      checks++;
      if (u_if.ufo_active !== 1'b1 || u_if.ufo_dir !== exp_dir || u_if.ufo_x !== exp_x) begin
         errors++;
         $display("[TB] FAIL spawn_4th: active=%0d dir=%0d x=%0d, required 1 %0d %0d",
                  u_if.ufo_active, u_if.ufo_dir, u_if.ufo_x, exp_dir, exp_x);
      end
   endtask

   task automatic test_fly(input int want);
      int bad = 0;
      int bad_i = 0;
      logic [9:0] bad_x = '0;
      logic [9:0] end_x;
      spawn_with_dir(want);
      for (int i = 1; i <= 312; i++) begin
         pulse_frame();
         exp_x = (want == 0) ? 10'(2 * i) : 10'(624 - 2 * i);
         if (u_if.ufo_x !== exp_x || u_if.ufo_active !== 1'b1) begin
            if (bad == 0) begin
               bad_i = i;
               bad_x = u_if.ufo_x;
            end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL fly_dir%0d_path: step %0d x=%0d, required %0d (%0d bad steps)",
                  want, bad_i, bad_x, (want == 0) ? 2 * bad_i : 624 - 2 * bad_i, bad);
      end
      end_x = (want == 0) ? 10'd624 : 10'd0;
      pulse_frame();
      checks++;
      if (u_if.ufo_active !== 1'b0 || u_if.ufo_x !== end_x) begin
         errors++;
         $display("[TB] FAIL fly_dir%0d_exit: active=%0d x=%0d, required 0 and %0d",
                  want, u_if.ufo_active, u_if.ufo_x, end_x);
      end
      for (int i = 0; i < 3; i++) pulse_frame();
      checks++;
      if (u_if.ufo_active !== 1'b0) begin
         errors++;
         $display("[TB] FAIL respawn_early: active=%0d, required 0", u_if.ufo_active);
      end
      pulse_frame();
      exp_dir = lfsr_at_frame[0];
      checks++;
      if (u_if.ufo_active !== 1'b1 || u_if.ufo_dir !== exp_dir) begin
         errors++;
         $display("[TB] FAIL respawn: active=%0d dir=%0d, required 1 %0d",
                  u_if.ufo_active, u_if.ufo_dir, exp_dir);
      end
   endtask

   task automatic test_hit();
      int extra = 0;
      logic [6:0] exp_pts;
      spawn_with_dir(2);
      pulse_frame();
      pulse_frame();
      exp_x = exp_dir ? 10'd620 : 10'd4;
      @(posedge clk); #1;
      u_if.ufo_collision = 1'b1;
      frame_now();
      exp_pts = points_tbl[lfsr_at_frame[1:0]];
      checks++;
      if (u_if.bonus_valid !== 1'b1 || u_if.bonus_points !== exp_pts) begin
         errors++;
         $display("[TB] FAIL hit_bonus: valid=%0d points=%0d, required 1 %0d",
                  u_if.bonus_valid, u_if.bonus_points, exp_pts);
      end
      checks++;
      if (u_if.ufo_exploding !== 1'b1 || u_if.ufo_active !== 1'b0 || u_if.ufo_x !== exp_x) begin
         errors++;
         $display("[TB] FAIL hit_state: expl=%0d active=%0d x=%0d, required 1 0 %0d",
                  u_if.ufo_exploding, u_if.ufo_active, u_if.ufo_x, exp_x);
      end
      for (int i = 0; i < 19; i++) begin
         @(posedge clk); #1;
         if (u_if.bonus_valid === 1'b1) extra++;
      end
      u_if.ufo_collision = 1'b0;
      checks++;
      if (extra != 0 || u_if.bonus_points !== exp_pts) begin
         errors++;
         $display("[TB] FAIL hit_single: extra pulses=%0d points=%0d, required 0 and %0d",
                  extra, u_if.bonus_points, exp_pts);
      end
      pulse_frame();
      pulse_frame();
      checks++;
      if (u_if.ufo_exploding !== 1'b1 || u_if.ufo_x !== exp_x) begin
         errors++;
         $display("[TB] FAIL explode_hold: expl=%0d x=%0d, required 1 %0d",
                  u_if.ufo_exploding, u_if.ufo_x, exp_x);
      end
      pulse_frame();
      checks++;
      if (u_if.ufo_exploding !== 1'b0 || u_if.ufo_active !== 1'b0) begin
         errors++;
         $display("[TB] FAIL explode_end: expl=%0d active=%0d, required 0 0",
                  u_if.ufo_exploding, u_if.ufo_active);
      end
   endtask

   task automatic test_done();
      int moved = 0;
      int bonus_seen = 0;
      spawn_with_dir(2);
      for (int i = 0; i < 3; i++) pulse_frame();
      exp_x = exp_dir ? 10'd618 : 10'd6;
      u_if.done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 4) u_if.ufo_collision = 1'b1;
         frame_now();
         u_if.ufo_collision = 1'b0;
         if (u_if.ufo_x !== exp_x || u_if.ufo_active !== 1'b1 || u_if.ufo_exploding !== 1'b0) moved++;
         if (u_if.bonus_valid !== 1'b0) bonus_seen++;
      end
      checks++;
      if (moved != 0) begin
         errors++;
         $display("[TB] FAIL done_freeze: %0d frames changed state, last x=%0d, required 0 (x=%0d)",
                  moved, u_if.ufo_x, exp_x);
      end
      checks++;
      if (bonus_seen != 0) begin
         errors++;
         $display("[TB] FAIL done_bonus: %0d bonus pulses, required 0", bonus_seen);
      end
      u_if.done = 1'b0;
      pulse_frame();
      exp_x = exp_dir ? 10'd616 : 10'd8;
      checks++;
      if (u_if.ufo_x !== exp_x || u_if.ufo_active !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_resume: x=%0d active=%0d, required %0d 1",
                  u_if.ufo_x, u_if.ufo_active, exp_x);
      end
   endtask

   task automatic test_arst_explode();
      spawn_with_dir(2);
      @(posedge clk); #1;
      u_if.ufo_collision = 1'b1;
      @(posedge clk); #1;
      u_if.ufo_collision = 1'b0;
      pulse_frame();
      checks++;
      if (u_if.ufo_exploding !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arst_pre: expl=%0d, required 1", u_if.ufo_exploding);
      end
      pulse_arst();
      checks++;
      if (u_if.ufo_active !== 1'b0 || u_if.ufo_exploding !== 1'b0 || u_if.ufo_dir !== 1'b0 ||
          u_if.ufo_x !== 10'd0 || u_if.ufo_y !== 10'd40 || u_if.bonus_valid !== 1'b0 ||
          u_if.bonus_points !== 7'd0) begin
         errors++;
         $display("[TB] FAIL arst_outputs: act=%0d expl=%0d dir=%0d x=%0d y=%0d bv=%0d bp=%0d, required 0 0 0 0 40 0 0",
                  u_if.ufo_active, u_if.ufo_exploding, u_if.ufo_dir, u_if.ufo_x, u_if.ufo_y,
                  u_if.bonus_valid, u_if.bonus_points);
      end
      for (int i = 0; i < 3; i++) pulse_frame();
      checks++;
      if (u_if.ufo_active !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arst_respawn_early: active=%0d, required 0", u_if.ufo_active);
      end
      pulse_frame();
      checks++;
      if (u_if.ufo_active !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arst_respawn: active=%0d, required 1", u_if.ufo_active);
      end
   endtask

   task automatic test_async_reset();
      spawn_with_dir(2);
      pulse_frame();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (u_if.ufo_active !== 1'b0 || u_if.ufo_x !== 10'd0) begin
         errors++;
         $display("[TB] FAIL async_rst: active=%0d x=%0d, required 0 0", u_if.ufo_active, u_if.ufo_x);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      u_if.frame         = 1'b0;
      u_if.done          = 1'b0;
      u_if.ufo_collision = 1'b0;
      test_reset();
      test_spawn();
      test_fly(0);
      test_fly(1);
      test_hit();
      test_done();
      test_arst_explode();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
